// File: rtl/ifetch_unit_if.sv
// Fetch-side bus: CPU port toward the instruction cache plus the decode
// handshake. The fetch unit is the master; cache and decode sit on the slave side.
interface ifetch_unit_if;
    logic [11:0] cpu_req_addr;
    logic        cpu_req_valid;
    logic        cpu_req_rw;
    logic [31:0] cpu_data_write;
    logic        cpu_jump;
    logic [31:0] cpu_data_read;
    logic        cpu_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [11:0] if_pc;
    logic        id_ready;

    modport master (
        output cpu_req_addr, cpu_req_valid, cpu_req_rw, cpu_data_write, cpu_jump,
        output if_valid, if_inst, if_pc,
        input  cpu_data_read, cpu_ready, id_ready
    );

    modport slave (
        input  cpu_req_addr, cpu_req_valid, cpu_req_rw, cpu_data_write, cpu_jump,
        input  if_valid, if_inst, if_pc,
        output cpu_data_read, cpu_ready, id_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the word-addressed PC, keeps at most one read
// outstanding at the instruction cache and buffers returned words in a
// 2-entry queue feeding decode. A redirect flushes the queue; a request
// already in flight completes at the cache and its data is thrown away.
module ifetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_valid,
    input  logic [11:0] jump_target,
    ifetch_unit_if.master bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        START,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic [1:0]  count_q, count_d;

    // Queue storage; slot 0 is always the head.
    logic [11:0] q_pc_q   [2];
    logic [31:0] q_inst_q [2];

    logic head_valid;
    logic push;
    logic pop;

    assign head_valid = (count_q != 2'd0);
    assign pop        = head_valid && bus.id_ready;
    // A response is kept only if it belongs to the current stream and no
    // redirect arrives in the same cycle.
    assign push       = (state_q == WAIT) && bus.cpu_ready && !drop_q && !jump_valid;

    // Occupancy after this cycle's flush/push/pop; the flush wins over both.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (jump_valid) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Next state, PC and discard flag; a new request is only launched when the
    // queue will have room for its response.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;

        case (state_q)
            START: state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.cpu_ready) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        pc_d = req_addr_q + 12'd1;
                    end
                    state_d = (count_d < 2'd2) ? ISSUE : HOLD;
                end
            end
            HOLD: begin
                if (count_d < 2'd2) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = START;
        endcase

        // Redirect overrides the sequential PC; an access still pending at the
        // cache is marked for discard.
        if (jump_valid) begin
            pc_d = jump_target;
            if ((state_q == ISSUE) || ((state_q == WAIT) && !bus.cpu_ready)) begin
                drop_d = 1'b1;
            end
        end
    end

    // Request address is captured on entry to ISSUE and held through WAIT.
    assign req_addr_d = (state_d == ISSUE) ? pc_d : req_addr_q;

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
        end
    end

    // Queue slots: a push lands behind the head, or becomes the head when the
    // queue is empty or the head leaves in the same cycle; a pop shifts slot 1 forward.
    // NOTE: queue payload has no reset; count_q says which slots are meaningful and the outputs mask empty slots.
    always_ff @(posedge clk) begin
        if (push) begin
            if (pop || (count_q == 2'd0)) begin
                q_pc_q[0]   <= req_addr_q;
                q_inst_q[0] <= bus.cpu_data_read;
            end else begin
                q_pc_q[1]   <= req_addr_q;
                q_inst_q[1] <= bus.cpu_data_read;
            end
        end else if (pop) begin
            q_pc_q[0]   <= q_pc_q[1];
            q_inst_q[0] <= q_inst_q[1];
        end
    end

    assign bus.cpu_req_valid  = (state_q == ISSUE);
    assign bus.cpu_req_addr   = req_addr_q;
    assign bus.cpu_req_rw     = 1'b0;
    assign bus.cpu_data_write = 32'd0;
    assign bus.cpu_jump       = drop_q;

    assign bus.if_valid = head_valid;
    assign bus.if_inst  = head_valid ? q_inst_q[0] : NOP;
    assign bus.if_pc    = head_valid ? q_pc_q[0] : 12'd0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small instruction-cache responder
// whose latency (cycles from ISSUE to cpu_ready) is set per scenario.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        jump_valid;
    logic [11:0] jump_target;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(12'h010)) dut (
        .clk        (clk),
        .rst        (rst),
        .jump_valid (jump_valid),
        .jump_target(jump_target),
        .bus        (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Cache responder state.
    logic        busy;
    int          cnt;
    int          lat;
    logic [11:0] c_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [31:0] dat(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cache model, evaluated once per cycle just after the rising edge.
    task automatic cache_update();
        bus.cpu_ready = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (cnt == 0) begin
                    bus.cpu_ready     = 1'b1;
                    bus.cpu_data_read = dat(c_addr);
                    busy              = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (bus.cpu_req_valid) begin
                busy   = 1'b1;
                c_addr = bus.cpu_req_addr;
                cnt    = lat - 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        jump_valid = 1'b0;
        cache_update();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        jump_valid    = 1'b0;
        bus.cpu_ready = 1'b0;
        busy          = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'd0, bus.cpu_req_valid}, 32'd0);
        check({tag, "_req_addr"},  {20'd0, bus.cpu_req_addr}, 32'h010);
        check({tag, "_req_rw"},    {31'd0, bus.cpu_req_rw}, 32'd0);
        check({tag, "_wdata"},     bus.cpu_data_write, 32'd0);
        check({tag, "_cpu_jump"},  {31'd0, bus.cpu_jump}, 32'd0);
        check({tag, "_if_valid"},  {31'd0, bus.if_valid}, 32'd0);
        check({tag, "_if_inst"},   bus.if_inst, 32'h0000_0013);
        check({tag, "_if_pc"},     {20'd0, bus.if_pc}, 32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        jump_valid        = 1'b0;
        jump_target       = 12'h000;
        bus.cpu_ready     = 1'b0;
        bus.cpu_data_read = 32'd0;
        bus.id_ready      = 1'b1;
        busy              = 1'b0;
        cnt               = 0;
        lat               = 2;
        c_addr            = 12'h000;
        #2;
        check_reset_outputs("rst");

        // Hits with decode always ready: ISSUE every 3 cycles, entry visible 3 later.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            check($sformatf("hit_req_valid_c%0d", c), {31'd0, bus.cpu_req_valid},
                  (c % 3 == 1) ? 32'd1 : 32'd0);
            if (c % 3 == 1) begin
                check($sformatf("hit_req_addr_c%0d", c), {20'd0, bus.cpu_req_addr},
                      32'h010 + 32'((c - 1) / 3));
            end
            check($sformatf("hit_if_valid_c%0d", c), {31'd0, bus.if_valid},
                  (c >= 4 && c % 3 == 1) ? 32'd1 : 32'd0);
            if (c >= 4 && c % 3 == 1) begin
                check($sformatf("hit_if_pc_c%0d", c), {20'd0, bus.if_pc},
                      32'h010 + 32'((c - 4) / 3));
                check($sformatf("hit_if_inst_c%0d", c), bus.if_inst,
                      dat(12'h010 + 12'((c - 4) / 3)));
            end
        end

        // Decode stalled: two entries fill the queue, then no further requests.
        bus.id_ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check($sformatf("full_req_valid_c%0d", c), {31'd0, bus.cpu_req_valid},
                  (c == 1 || c == 4) ? 32'd1 : 32'd0);
            check($sformatf("full_if_valid_c%0d", c), {31'd0, bus.if_valid},
                  (c >= 4) ? 32'd1 : 32'd0);
        end
        check("full_head_pc", {20'd0, bus.if_pc}, 32'h010);
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        check("full_reissue_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("full_reissue_addr", {20'd0, bus.cpu_req_addr}, 32'h012);
        check("full_new_head_pc", {20'd0, bus.if_pc}, 32'h011);
        check("full_new_head_inst", bus.if_inst, dat(12'h011));

        // Miss: response 20 cycles after ISSUE, address held throughout.
        bus.id_ready = 1'b1;
        lat = 20;
        do_reset();
        cyc();
        check("miss_issue_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("miss_issue_addr", {20'd0, bus.cpu_req_addr}, 32'h010);
        for (int c = 2; c <= 21; c++) begin
            cyc();
            check($sformatf("miss_addr_c%0d", c), {20'd0, bus.cpu_req_addr}, 32'h010);
            check($sformatf("miss_no_req_c%0d", c), {31'd0, bus.cpu_req_valid}, 32'd0);
        end
        lat = 2;
        cyc();
        check("miss_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("miss_if_inst", bus.if_inst, dat(12'h010));
        check("miss_next_addr", {20'd0, bus.cpu_req_addr}, 32'h011);

        // Redirect in the WAIT cycle before the response.
        do_reset();
        cyc();
        cyc();
        jump_valid  = 1'b1;
        jump_target = 12'h080;
        cyc();
        check("jw_cpu_jump_set", {31'd0, bus.cpu_jump}, 32'd1);
        check("jw_if_valid_flushed", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        check("jw_cpu_jump_clr", {31'd0, bus.cpu_jump}, 32'd0);
        check("jw_issue_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("jw_issue_addr", {20'd0, bus.cpu_req_addr}, 32'h080);
        check("jw_dropped", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        cyc();
        cyc();
        check("jw_first_valid", {31'd0, bus.if_valid}, 32'd1);
        check("jw_first_pc", {20'd0, bus.if_pc}, 32'h080);
        check("jw_first_inst", bus.if_inst, dat(12'h080));

        // Redirect coincident with cpu_ready while one entry is queued and decode ready.
        bus.id_ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 6; c++) cyc();
        check("jr_pre_head_pc", {20'd0, bus.if_pc}, 32'h010);
        check("jr_pre_ready", {31'd0, bus.cpu_ready}, 32'd1);
        bus.id_ready = 1'b1;
        jump_valid   = 1'b1;
        jump_target  = 12'h200;
        cyc();
        check("jr_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("jr_issue_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("jr_issue_addr", {20'd0, bus.cpu_req_addr}, 32'h200);
        check("jr_cpu_jump", {31'd0, bus.cpu_jump}, 32'd0);
        cyc();
        check("jr_gap_c8", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        check("jr_gap_c9", {31'd0, bus.if_valid}, 32'd0);
        cyc();
        check("jr_first_valid", {31'd0, bus.if_valid}, 32'd1);
        check("jr_first_pc", {20'd0, bus.if_pc}, 32'h200);

        // Redirect during ISSUE to 12'hFFF, then PC wraps to 12'h000.
        do_reset();
        cyc();
        check("wr_issue_addr0", {20'd0, bus.cpu_req_addr}, 32'h010);
        jump_valid  = 1'b1;
        jump_target = 12'hFFF;
        cyc();
        check("wr_cpu_jump_c2", {31'd0, bus.cpu_jump}, 32'd1);
        check("wr_no_req_c2", {31'd0, bus.cpu_req_valid}, 32'd0);
        cyc();
        check("wr_cpu_jump_c3", {31'd0, bus.cpu_jump}, 32'd1);
        cyc();
        check("wr_cpu_jump_c4", {31'd0, bus.cpu_jump}, 32'd0);
        check("wr_issue_fff_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("wr_issue_fff_addr", {20'd0, bus.cpu_req_addr}, 32'hFFF);
        cyc();
        cyc();
        lat          = 20;
        bus.id_ready = 1'b0;
        cyc();
        check("wr_issue_000_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("wr_issue_000_addr", {20'd0, bus.cpu_req_addr}, 32'h000);
        check("wr_head_pc", {20'd0, bus.if_pc}, 32'hFFF);
        check("wr_head_inst", bus.if_inst, dat(12'hFFF));

        // Asynchronous reset in the middle of the miss to 12'h000.
        for (int c = 0; c < 5; c++) cyc();
        check("mr_pre_valid", {31'd0, bus.if_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("mr");
        cyc();
        cyc();
        lat          = 2;
        rst          = 1'b0;
        bus.id_ready = 1'b1;
        cyc();
        check("mr_restart_valid", {31'd0, bus.cpu_req_valid}, 32'd1);
        check("mr_restart_addr", {20'd0, bus.cpu_req_addr}, 32'h010);
        cyc();
        cyc();
        cyc();
        check("mr_restart_if_pc", {20'd0, bus.if_pc}, 32'h010);
        check("mr_restart_if_inst", bus.if_inst, dat(12'h010));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the word-addressed program counter and issues one read request at a time on the cache's CPU-side port. Returned instructions are buffered in a 2-entry queue that feeds decode through a valid/ready handshake. Redirects (jump/branch) flush the queue, and the in-flight cache access completes and is discarded.

## Interface
- RESET_PC, 12'h000, word address fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_valid  in  1  redirect request, one-cycle pulse
- jump_target  in  12  redirect word address, sampled when jump_valid=1
- cpu_req_addr  out  12  cache request word address ([1:0] word-in-block, [5:2] set, [11:6] tag)
- cpu_req_valid  out  1  request strobe, high for exactly the ISSUE cycle
- cpu_req_rw  out  1  constant 0 (read only)
- cpu_data_write  out  32  constant 0
- cpu_jump  out  1  high while the outstanding request is to be discarded
- cpu_data_read  in  32  cache read data, valid when cpu_ready=1
- cpu_ready  in  1  one-cycle completion pulse from cache
- if_valid  out  1  queue head holds a valid instruction
- if_inst  out  32  head instruction; 32'h00000013 when queue empty
- if_pc  out  12  head instruction word address; 0 when queue empty
- id_ready  in  1  decode accepts head this cycle

## Operation
- Registers: pc (next address to fetch), req_addr (drives cpu_req_addr), drop flag (drives cpu_jump), 2-entry queue of {pc, inst} with count 0..2, state.
- States: START, ISSUE, WAIT, HOLD.
  - START: reset state; next ISSUE.
  - ISSUE: cpu_req_valid=1, cpu_req_addr=req_addr (loaded with pc on entry). Next WAIT unconditionally.
  - WAIT: cpu_req_valid=0, req_addr held stable (cache uses it through miss/allocate). On cpu_ready: if drop=0, push {req_addr, cpu_data_read} and pc<=req_addr+1; if drop=1, discard and clear drop. Then ISSUE if count-after-update < 2, else HOLD.
  - HOLD: queue full; ISSUE on first cycle count drops below 2.
- Credit rule: at most one outstanding request; a request is issued only when count + 1 <= 2 after that cycle's push/pop, so a response always has a free slot.
- Pop: if_valid && id_ready removes head. Simultaneous push and pop at count=2 is impossible (credit rule); at count=1 head advances and new entry lands behind it, in order.
- Redirect (jump_valid=1): queue flushed (count<=0), pc<=jump_target.
  - In START/HOLD: next state ISSUE with target.
  - In ISSUE or WAIT without cpu_ready: drop<=1; state continues; on completion go ISSUE with pc (=target).
  - In WAIT with cpu_ready same cycle: response discarded, next ISSUE with target.
  - Second redirect while drop=1: pc<=newest target; drop stays 1.
  - Flush beats a same-cycle pop or push.
- pc and req_addr wrap 12'hFFF -> 12'h000.

## Timing
- Reset values: cpu_req_valid 0, cpu_req_addr RESET_PC, cpu_req_rw 0, cpu_data_write 0, cpu_jump 0, if_valid 0, if_inst 32'h00000013, if_pc 0; pc=RESET_PC, count 0, drop 0, state START.
- Reset mid-operation returns all of the above immediately. An outstanding cache access is abandoned; cache is reset by the same rst.
- Cache hit: ISSUE at cycle t, cache CompareTag t+1, cpu_ready at t+2, entry visible (if_valid=1) at t+3, next ISSUE at t+3. Steady-state hit throughput is 1 instruction / 3 cycles.
- Miss: WAIT extends until cpu_ready; cpu_req_addr must not change during WAIT.
- if_valid/if_inst/if_pc are combinational from the queue head register; no output depends combinationally on cpu_ready or jump_valid.

## Test plan
- Reset release, RESET_PC=12'h010, all hits, id_ready=1 -> cpu_req_valid pulses every 3 cycles at addrs 010,011,012; if_pc sequence 010,011,012 with matching if_inst.
- id_ready=0 after reset -> two entries accepted (010, 011), then HOLD with no cpu_req_valid. Set id_ready=1 for one cycle -> head 011, one ISSUE at 012.
- Miss at 010 with cpu_ready delayed 20 cycles -> cpu_req_addr=010 stable all 20 cycles, single cpu_req_valid pulse, if_inst equals returned data.
- jump_valid with target 12'h080 in the WAIT cycle before cpu_ready -> cpu_jump=1 until completion, response discarded, queue empty, next ISSUE addr 080, first if_pc 080.
- jump_valid coincident with cpu_ready and with queue count=1 and id_ready=1 -> no entry delivered from old stream, next ISSUE at target.
- pc=12'hFFF fetch -> next ISSUE addr 12'h000; rst asserted mid-miss -> outputs at reset values within the same cycle, restart at RESET_PC.
